// File: rtl/ul4_arb.sv
// Two-requester front end sharing a single 4-bit logic unit (ul4).
// Round-robin grant, three-state IDLE/EXEC/DONE pipeline with result backpressure.

module ul4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] s_i,
  output logic [3:0] y_o
);

  always_comb begin
    y_o = 4'h0;
    unique case (s_i)
      2'b00: y_o = a_i & b_i;
      2'b01: y_o = a_i | b_i;
      2'b10: y_o = a_i ^ b_i;
      2'b11: y_o = ~a_i;
      default: y_o = 4'h0;
    endcase
  end

endmodule

module ul4_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v0_i,
  input  logic       v1_i,
  input  logic [3:0] a0_i,
  input  logic [3:0] b0_i,
  input  logic [3:0] a1_i,
  input  logic [3:0] b1_i,
  input  logic [1:0] s0_i,
  input  logic [1:0] s1_i,
  output logic       rdy0_o,
  output logic       rdy1_o,
  output logic [3:0] res_o,
  output logic       res_id_o,
  output logic       res_v_o,
  input  logic       res_rdy_i,
  output logic [7:0] ops_o
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  op_a_q, op_a_d;
  logic [3:0]  op_b_q, op_b_d;
  logic [1:0]  op_s_q, op_s_d;
  logic        op_id_q, op_id_d;
  logic [3:0]  res_q, res_d;
  logic        res_id_q, res_id_d;
  logic        res_v_q, res_v_d;
  logic [7:0]  ops_q, ops_d;
  logic        grant;
  logic        accept;
  logic [3:0]  alu_y;

  ul4 u_ul4 (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .s_i (op_s_q),
    .y_o (alu_y)
  );

  // On a tie the requester that did not win last time gets the unit.
  always_comb begin
    if (v0_i && v1_i) begin
      grant = ~last_grant_q;
    end else begin
      grant = ~v0_i;
    end
  end

  // rst_n gating keeps both ready lines low throughout reset.
  assign rdy0_o = rst_n && (state_q == StIdle) && v0_i && !grant;
  assign rdy1_o = rst_n && (state_q == StIdle) && v1_i && grant;
  assign accept = rdy0_o || rdy1_o;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_s_d       = op_s_q;
    op_id_d      = op_id_q;
    res_d        = res_q;
    res_id_d     = res_id_q;
    res_v_d      = res_v_q;
    ops_d        = ops_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_grant_d = grant;
          op_id_d      = grant;
          op_a_d       = grant ? a1_i : a0_i;
          op_b_d       = grant ? b1_i : b0_i;
          op_s_d       = grant ? s1_i : s0_i;
          state_d      = StExec;
        end
      end
      StExec: begin
        res_d    = alu_y;
        res_id_d = op_id_q;
        res_v_d  = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (res_rdy_i) begin
          res_v_d = 1'b0;
          ops_d   = ops_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      op_a_q       <= 4'h0;
      op_b_q       <= 4'h0;
      op_s_q       <= 2'b00;
      op_id_q      <= 1'b0;
      res_q        <= 4'h0;
      res_id_q     <= 1'b0;
      res_v_q      <= 1'b0;
      ops_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_s_q       <= op_s_d;
      op_id_q      <= op_id_d;
      res_q        <= res_d;
      res_id_q     <= res_id_d;
      res_v_q      <= res_v_d;
      ops_q        <= ops_d;
    end
  end

  assign res_o    = res_q;
  assign res_id_o = res_id_q;
  assign res_v_o  = res_v_q;
  assign ops_o    = ops_q;

endmodule

// File: tb/tb_ul4_arb.sv
// Randomised and directed bench for ul4_arb against a transaction-level reference model.

module tb_ul4_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] s0, s1;
  logic       res_rdy;
  logic       rdy0_o, rdy1_o, res_id_o, res_v_o;
  logic [3:0] res_o;
  logic [7:0] ops_o;

  int nvec = 0;
  int nerr = 0;

  // Reference model state: one outstanding operation at most.
  logic       m_busy, m_pend, m_lg, m_id, m_last_id;
  logic [3:0] m_val, m_last_res;
  logic [7:0] m_ops;
  int         cyc, acc_cyc;
  int         cnt_rdy0, cnt_rv;
  logic [4:0] log_q[$];

  always #5 clk = ~clk;

  ul4_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .v0_i      (v0),
    .v1_i      (v1),
    .a0_i      (a0),
    .b0_i      (b0),
    .a1_i      (a1),
    .b1_i      (b1),
    .s0_i      (s0),
    .s1_i      (s1),
    .rdy0_o    (rdy0_o),
    .rdy1_o    (rdy1_o),
    .res_o     (res_o),
    .res_id_o  (res_id_o),
    .res_v_o   (res_v_o),
    .res_rdy_i (res_rdy),
    .ops_o     (ops_o)
  );

  function automatic logic [3:0] ref_op(logic [3:0] a, logic [3:0] b, logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_lg = 1; m_id = 0; m_val = 0;
    m_last_res = 0; m_last_id = 0; m_ops = 0;
  endtask

  // One clock: observe at negedge+1, advance the model, return at posedge+1.
  task automatic step();
    logic e_r0, e_r1, e_rv, g, acc, cons;
    @(negedge clk); #1;
    g = 0;
    if (!rst_n || m_busy) begin
      e_r0 = 0; e_r1 = 0;
    end else begin
      g = (v0 && v1) ? ~m_lg : (v0 ? 1'b0 : 1'b1);
      e_r0 = v0 && !g;
      e_r1 = v1 && g;
    end
    e_rv = rst_n && m_pend && (cyc - acc_cyc >= 2);
    if (rdy0_o) cnt_rdy0++;
    if (res_v_o) cnt_rv++;
    nvec++;
    if (rdy0_o !== e_r0 || rdy1_o !== e_r1) begin
      nerr++;
      $display("FAIL rdy cyc=%0d got=%b%b exp=%b%b", cyc, rdy1_o, rdy0_o, e_r1, e_r0);
    end
    nvec++;
    if (res_v_o !== e_rv) begin
      nerr++;
      $display("FAIL res_v cyc=%0d got=%b exp=%b", cyc, res_v_o, e_rv);
    end
    nvec++;
    if (ops_o !== m_ops) begin
      nerr++;
      $display("FAIL ops cyc=%0d got=%0d exp=%0d", cyc, ops_o, m_ops);
    end
    nvec++;
    if (e_rv) begin
      if (res_o !== m_val || res_id_o !== m_id) begin
        nerr++;
        $display("FAIL result cyc=%0d got=%h/%b exp=%h/%b", cyc, res_o, res_id_o, m_val, m_id);
      end
    end else if (res_o !== m_last_res || res_id_o !== m_last_id) begin
      nerr++;
      $display("FAIL held_res cyc=%0d got=%h/%b exp=%h/%b", cyc, res_o, res_id_o,
               m_last_res, m_last_id);
    end
    acc  = e_r0 || e_r1;
    cons = e_rv && res_rdy;
    if (cons) begin
      m_pend = 0; m_busy = 0; m_ops = m_ops + 8'd1;
      m_last_res = m_val; m_last_id = m_id;
      log_q.push_back({m_id, m_val});
    end
    if (acc) begin
      m_pend = 1; m_busy = 1; m_id = g; m_lg = g; acc_cyc = cyc;
      m_val = g ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset(); step(); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; v0 = 1; v1 = 1; model_reset();
    step(); step();
    nvec++;
    if (ops_o !== 8'd0 || res_o !== 4'd0 || res_v_o !== 1'b0 || res_id_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state got ops=%0d res=%h v=%b id=%b", ops_o, res_o, res_v_o, res_id_o);
    end
    v0 = 0; v1 = 0; rst_n = 1;
    step();
  endtask

  task automatic test_single_op();
    int base = log_q.size();
    cnt_rdy0 = 0; cnt_rv = 0;
    v0 = 1; a0 = 4'b1100; b0 = 4'b1010; s0 = 2'b00; res_rdy = 1;
    step(); v0 = 0;
    repeat (4) step();
    nvec++;
    if (log_q.size() != base + 1 || log_q[base] !== {1'b0, 4'b1000}) begin
      nerr++;
      $display("FAIL single_op got n=%0d entry=%h exp n=1 entry=08", log_q.size() - base,
               (log_q.size() > base) ? log_q[base] : 5'h1f);
    end
    nvec++;
    if (cnt_rdy0 != 1 || cnt_rv != 1 || ops_o !== 8'd1) begin
      nerr++;
      $display("FAIL single_counts got rdy0=%0d rv=%0d ops=%0d exp 1/1/1", cnt_rdy0, cnt_rv, ops_o);
    end
  endtask

  task automatic test_tie();
    int base;
    logic [4:0] exp_e[3];
    do_reset();
    base = log_q.size();
    exp_e[0] = {1'b0, 4'b0111}; exp_e[1] = {1'b1, 4'b1010}; exp_e[2] = {1'b0, 4'b0111};
    v0 = 1; v1 = 1; a0 = 4'b0011; b0 = 4'b0101; s0 = 2'b01;
    a1 = 4'b1111; b1 = 4'b0101; s1 = 2'b10; res_rdy = 1;
    repeat (9) step();
    v0 = 0; v1 = 0;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (log_q.size() <= base + k || log_q[base + k] !== exp_e[k]) begin
        nerr++;
        $display("FAIL tie_order k=%0d got=%h exp=%h", k,
                 (log_q.size() > base + k) ? log_q[base + k] : 5'h1f, exp_e[k]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] e;
    logic [7:0] o;
    bit seen = 0;
    do_reset();
    v0 = 1; a0 = 4'($urandom); b0 = 4'($urandom); s0 = 2'($urandom); res_rdy = 0;
    e = ref_op(a0, b0, s0);
    step(); v0 = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step();
      seen = res_v_o;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL bp_timeout got res_v=0 exp=1");
    end
    o = m_ops;
    v0 = 1; v1 = 1;
    repeat (5) begin
      step();
      nvec++;
      if (res_o !== e || res_id_o !== 1'b0 || rdy0_o !== 1'b0 || rdy1_o !== 1'b0 ||
          ops_o !== o) begin
        nerr++;
        $display("FAIL bp_hold got res=%h id=%b rdy=%b%b ops=%0d exp res=%h id=0 rdy=00 ops=%0d",
                 res_o, res_id_o, rdy1_o, rdy0_o, ops_o, e, o);
      end
    end
    v0 = 0; v1 = 0; res_rdy = 1;
    step();
    nvec++;
    if (ops_o !== o + 8'd1 || res_v_o !== 1'b0 || res_o !== e) begin
      nerr++;
      $display("FAIL bp_consume got ops=%0d v=%b res=%h exp ops=%0d v=0 res=%h",
               ops_o, res_v_o, res_o, o + 8'd1, e);
    end
  endtask

  task automatic test_not_wrap();
    int base, bad = 0;
    do_reset();
    base = log_q.size();
    v0 = 1; a0 = 4'b0110; b0 = 4'($urandom); s0 = 2'b11; res_rdy = 1;
    for (int i = 0; i < 900 && log_q.size() < base + 256; i++) step();
    v0 = 0;
    nvec++;
    if (log_q.size() != base + 256) begin
      nerr++;
      $display("FAIL wrap_count got=%0d exp=256", log_q.size() - base);
    end
    for (int k = base; k < log_q.size(); k++) if (log_q[k][3:0] !== 4'b1001) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL not_result got %0d bad results exp 0", bad);
    end
    nvec++;
    if (ops_o !== 8'd0) begin
      nerr++;
      $display("FAIL ops_wrap got=%0d exp=0", ops_o);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    v0 = 1; a0 = 4'hf; b0 = 4'hf; s0 = 2'b00; res_rdy = 1;
    step(); v0 = 0; repeat (3) step();
    v0 = 1; a0 = 4'h5; s0 = 2'b11;
    step(); v0 = 0;
    rst_n = 0; #1;
    nvec++;
    if (res_v_o !== 1'b0 || res_o !== 4'd0 || ops_o !== 8'd0 || rdy0_o !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset got v=%b res=%h ops=%0d rdy0=%b exp 0/0/0/0",
               res_v_o, res_o, ops_o, rdy0_o);
    end
    model_reset();
    step(); step();
    rst_n = 1;
    v1 = 1; a1 = 4'h3; b1 = 4'h9; s1 = 2'b10;
    step();
    nvec++;
    if (log_q.size() == 0 || m_id !== 1'b1 || !m_pend) begin
      nerr++;
      $display("FAIL post_reset_v1 got model id=%b pend=%b exp id=1 pend=1", m_id, m_pend);
    end
    v1 = 0; repeat (3) step();
    rst_n = 0; model_reset(); step(); rst_n = 1;
    v0 = 1; v1 = 1;
    @(negedge clk); #1;
    nvec++;
    if (rdy0_o !== 1'b1 || rdy1_o !== 1'b0) begin
      nerr++;
      $display("FAIL post_reset_tie got rdy=%b%b exp=01", rdy1_o, rdy0_o);
    end
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v0 = ($urandom_range(0, 2) != 0); v1 = ($urandom_range(0, 2) != 0);
      a0 = 4'($urandom); b0 = 4'($urandom); s0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); s1 = 2'($urandom);
      res_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0; model_reset(); step(); rst_n = 1;
      end else begin
        step();
      end
    end
    v0 = 0; v1 = 0; res_rdy = 1;
    repeat (4) step();
  endtask

  initial begin
    rst_n = 0; v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; s0 = 0; s1 = 0; res_rdy = 1;
    cyc = 0; acc_cyc = 0; cnt_rdy0 = 0; cnt_rv = 0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_single_op();
    test_tie();
    test_backpressure();
    test_not_wrap();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ul4_arb.md
UL4_ARB -- requirements
Module: ul4_arb

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  Reset, asynchronous, active-low.
REQ-003 v0, v1  input  1 each  Request valid from requester 0 / 1.
REQ-004 a0, b0, a1, b1  input  4 each  Operands of requester 0 / 1.
REQ-005 s0, s1  input  2 each  Operation select of requester 0 / 1, passed unchanged to ul4 S.
REQ-006 rdy0, rdy1  output  1 each  Request accepted this cycle when vN && rdyN.
REQ-007 res  output  4  Registered logic result.
REQ-008 res_id  output  1  Requester that owns res.
REQ-009 res_v  output  1  res/res_id valid.
REQ-010 res_rdy  input  1  Consumer accepts result when res_v && res_rdy.
REQ-011 ops  output  8  Count of completed (consumed) results.

Function
REQ-012 Block SHALL instantiate exactly one ul4 and share it between the two requesters; no second logic datapath.
REQ-013 ul4 S encoding SHALL be: 00 A AND B, 01 A OR B, 10 A XOR B, 11 NOT A.
REQ-014 FSM states SHALL be IDLE, EXEC, DONE.
REQ-015 IDLE: rdyN SHALL be 1 only for the granted requester, and only when its vN=1; both rdy SHALL be 0 in EXEC and DONE.
REQ-016 Grant: one valid -> that one; both valid -> requester not equal to last_grant (round-robin); last_grant SHALL update on every acceptance.
REQ-017 On acceptance, A/B/S/id SHALL be latched into operand registers; IDLE->EXEC.
REQ-018 EXEC (one cycle): ul4 SHALL be driven from the operand registers; its output SHALL be registered into res, id into res_id; res_v SHALL rise; EXEC->DONE.
REQ-019 Latency: acceptance edge N -> res_v=1 after edge N+1.
REQ-020 DONE: res, res_id, res_v SHALL hold stable until res_v && res_rdy; on that edge res_v SHALL fall, ops SHALL increment, state SHALL go to IDLE.
REQ-021 No new request SHALL be accepted in the cycle a result is consumed; next acceptance earliest one cycle later (throughput 1 op / 3 cycles with res_rdy=1).
REQ-022 ops SHALL wrap 255->0 without side effect.
REQ-023 Requests deasserted before acceptance SHALL be dropped silently; vN changes during EXEC/DONE SHALL not affect the in-flight operation.
REQ-024 res SHALL retain its last value after consumption (res_v=0).

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, res=0, res_id=0, res_v=0, ops=0, last_grant=1 (requester 0 wins first tie), operand registers 0.
REQ-026 rdy0/rdy1 SHALL be 0 while rst_n=0.
REQ-027 Reset asserted in EXEC or DONE SHALL abort the operation; result SHALL never appear and ops SHALL not count it.

Verification
REQ-028 Single op: v0=1,a0=1100,b0=1010,s0=00, res_rdy=1 -> rdy0=1 one cycle, res=1000, res_id=0, res_v=1 one cycle, ops=1.
REQ-029 Tie arbitration: v0=v1=1 held, s0=01 (a0=0011,b0=0101), s1=10 (a1=1111,b1=0101) -> results in order id0 res=0111, id1 res=1010, id0 res=0111; never same id twice in a row.
REQ-030 Backpressure: res_rdy=0 for 5 cycles after res_v -> res, res_id stable, rdy0=rdy1=0, ops unchanged; res_rdy=1 -> consumed, ops+1.
REQ-031 NOT op and wrap: 256 ops with s=11, a=0110 -> each res=1001; ops returns to 0.
REQ-032 Reset mid-op: assert rst_n=0 in EXEC -> res_v=0, res=0, ops=0 at once; after release v1 alone granted first, v0/v1 tie grants requester 0.
